reaction_game_ctrl: RTL and testbench

Top-level sequencer for the reaction game. It drives the millisecond tick counter's enable and reset, and waits a randomised delay before lighting the stimulus LED. It then measures the player's reaction time in milliseconds, flags false starts and timeouts, and presents a result to the display logic. It sits between the debounced button inputs, the LFSR, the ms tick counter and the 7-segment driver.

---
 rtl/reaction_game_pkg.sv | 8 +
 rtl/reaction_game_if.sv | 37 +++
 rtl/reaction_game_best_tracker.sv | 23 ++
 rtl/reaction_game_ctrl.sv | 107 ++++++++++
 tb/tb_reaction_game_ctrl.sv | 146 ++++++++++++++
 5 files changed

// File: rtl/reaction_game_pkg.sv
// reaction_game_pkg: shared state encoding and default timing constants for the reaction game.
package reaction_game_pkg;
    typedef enum logic [1:0] {IDLE, WAIT_DELAY, REACT, DONE} game_state_t;
    localparam int MIN_DELAY_MS_DEF = 1000;
    localparam int RAND_BITS_DEF = 11;
    localparam int TIMEOUT_MS_DEF = 1000;
    localparam int RESULT_W_DEF = 10;
endpackage

// File: rtl/reaction_game_if.sv
// reaction_game_if: button/tick/LFSR inputs and display-side outputs of the game sequencer.
// REACTION_GAME_BEST_TIME_EN adds best_ms and new_best.
interface reaction_game_if import reaction_game_pkg::*; #(
    parameter int RAND_BITS = RAND_BITS_DEF,
    parameter int RESULT_W = RESULT_W_DEF
);
    logic start;
    logic react;
    logic ms_tick;
    logic [RAND_BITS-1:0] rand_val;
    logic cnt_en;
    logic cnt_reset;
    logic stim_led;
    logic busy;
    logic [RESULT_W-1:0] result_ms;
    logic result_valid;
    logic false_start;
    logic timeout;
`ifdef REACTION_GAME_BEST_TIME_EN
    logic [RESULT_W-1:0] best_ms;
    logic new_best;
`endif
    modport master (
        output start, react, ms_tick, rand_val,
        input cnt_en, cnt_reset, stim_led, busy, result_ms, result_valid, false_start, timeout
`ifdef REACTION_GAME_BEST_TIME_EN
        , input best_ms, new_best
`endif
    );
    modport slave (
        input start, react, ms_tick, rand_val,
        output cnt_en, cnt_reset, stim_led, busy, result_ms, result_valid, false_start, timeout
`ifdef REACTION_GAME_BEST_TIME_EN
        , output best_ms, new_best
`endif
    );
endinterface

// File: rtl/reaction_game_best_tracker.sv
// reaction_game_best_tracker: holds the fastest clean reaction time since reset.
module reaction_game_best_tracker #(
    parameter int RESULT_W = 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                upd,
    input  logic [RESULT_W-1:0] res,
    output logic [RESULT_W-1:0] best_ms,
    output logic                new_best
);
    logic better;
    assign better = upd && (res < best_ms);
    always_ff @(posedge clk) begin
        if (reset) begin
            best_ms <= '1;
            new_best <= 1'b0;
        end else begin
            new_best <= better;
            best_ms <= better ? res : best_ms;
        end
    end
endmodule

// File: rtl/reaction_game_ctrl.sv
// reaction_game_ctrl: sequences delay, stimulus and reaction timing for the reaction game.
// REACTION_GAME_BEST_TIME_EN enables the best-time tracker and its ports.
module reaction_game_ctrl import reaction_game_pkg::*; #(
    parameter int MIN_DELAY_MS = MIN_DELAY_MS_DEF,
    parameter int RAND_BITS = RAND_BITS_DEF,
    parameter int TIMEOUT_MS = TIMEOUT_MS_DEF,
    parameter int RESULT_W = RESULT_W_DEF
) (
    input logic clk,
    input logic reset,
    reaction_game_if.slave bus
);
    localparam int DELAY_W = $clog2(MIN_DELAY_MS + 2**RAND_BITS);
    localparam logic [1:0] S_IDLE = 2'(IDLE);
    localparam logic [1:0] S_WAIT = 2'(WAIT_DELAY);
    localparam logic [1:0] S_REACT = 2'(REACT);
    localparam logic [1:0] S_DONE = 2'(DONE);
    logic [1:0] state, state_d;
    logic [DELAY_W-1:0] delay_cnt, delay_d;
    logic [RESULT_W-1:0] elapsed, elapsed_d, result_d;
    logic valid_d, fs_d, to_d, en_d, rst_d;
    always_comb begin
        state_d = state;
        delay_d = delay_cnt;
        elapsed_d = elapsed;
        result_d = bus.result_ms;
        fs_d = bus.false_start;
        to_d = bus.timeout;
        valid_d = 1'b0;
        unique case (state)
            S_WAIT: begin
                if (bus.react) begin
                    state_d = S_DONE;
                    fs_d = 1'b1;
                    result_d = '0;
                    valid_d = 1'b1;
                end else if (bus.ms_tick) begin
                    delay_d = delay_cnt - DELAY_W'(1);
                    state_d = (delay_cnt == DELAY_W'(1)) ? S_REACT : S_WAIT;
                    elapsed_d = '0;
                end
            end
            S_REACT: begin
                if (bus.react) begin
                    state_d = S_DONE;
                    result_d = elapsed;
                    valid_d = 1'b1;
                end else if (bus.ms_tick && elapsed == RESULT_W'(TIMEOUT_MS - 1)) begin
                    state_d = S_DONE;
                    to_d = 1'b1;
                    result_d = RESULT_W'(TIMEOUT_MS);
                    valid_d = 1'b1;
                end else if (bus.ms_tick) begin
                    elapsed_d = elapsed + RESULT_W'(1);
                end
            end
            default: begin
                if (bus.start) begin
                    state_d = S_WAIT;
                    delay_d = DELAY_W'(MIN_DELAY_MS) + DELAY_W'(bus.rand_val);
                    fs_d = 1'b0;
                    to_d = 1'b0;
                end
            end
        endcase
        en_d = (state_d == S_WAIT) || (state_d == S_REACT);
        // the tick counter is cleared on stimulus onset so ms phase starts at the LED edge
        rst_d = !en_d || (state == S_WAIT && state_d == S_REACT);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            delay_cnt <= '0;
            elapsed <= '0;
            bus.cnt_en <= 1'b0;
            bus.cnt_reset <= 1'b1;
            bus.stim_led <= 1'b0;
            bus.busy <= 1'b0;
            bus.result_ms <= '0;
            bus.result_valid <= 1'b0;
            bus.false_start <= 1'b0;
            bus.timeout <= 1'b0;
        end else begin
            state <= state_d;
            delay_cnt <= delay_d;
            elapsed <= elapsed_d;
            bus.cnt_en <= en_d;
            bus.cnt_reset <= rst_d;
            bus.stim_led <= state_d == S_REACT;
            bus.busy <= en_d;
            bus.result_ms <= result_d;
            bus.result_valid <= valid_d;
            bus.false_start <= fs_d;
            bus.timeout <= to_d;
        end
    end
`ifdef REACTION_GAME_BEST_TIME_EN
    reaction_game_best_tracker #(.RESULT_W(RESULT_W)) best (
        .clk(clk),
        .reset(reset),
        .upd(valid_d && !fs_d && !to_d),
        .res(result_d),
        .best_ms(bus.best_ms),
        .new_best(bus.new_best)
    );
`endif
endmodule

// File: tb/tb_reaction_game_ctrl.sv
// tb_reaction_game_ctrl: directed checks of the reaction game sequencer with a 4-cycle ms tick.
module tb_reaction_game_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  reaction_game_if #(.RAND_BITS(2), .RESULT_W(10)) bus ();
  reaction_game_ctrl #(.MIN_DELAY_MS(3), .RAND_BITS(2), .TIMEOUT_MS(20), .RESULT_W(10)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic cyc(input logic s, input logic r, input logic t);
    bus.start = s;
    bus.react = r;
    bus.ms_tick = t;
    @(negedge clk);
    bus.start = 1'b0;
    bus.react = 1'b0;
    bus.ms_tick = 1'b0;
  endtask
  task automatic tick();
    repeat (3) cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
  endtask
  task automatic play(input logic [1:0] rd, input int n);
    bus.rand_val = rd;
    cyc(1'b1, 1'b0, 1'b0);
    repeat (3 + int'(rd)) tick();
    repeat (n) tick();
    cyc(1'b0, 1'b1, 1'b0);
  endtask
  initial begin
    bus.start = 1'b0;
    bus.react = 1'b0;
    bus.ms_tick = 1'b0;
    bus.rand_val = 2'd2;
    repeat (2) cyc(1'b0, 1'b0, 1'b0);
    chk("rst_cnt_reset", bus.cnt_reset, 1'b1);
    chk("rst_cnt_en", bus.cnt_en, 1'b0);
    chk("rst_led", bus.stim_led, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_result", bus.result_ms, 10'd0);
    chk("rst_valid", bus.result_valid, 1'b0);
    chk("rst_flags", {bus.false_start, bus.timeout}, 2'b00);
    reset = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    chk("start_busy", bus.busy, 1'b1);
    chk("start_cnt", {bus.cnt_en, bus.cnt_reset}, 2'b10);
    tick();
    cyc(1'b1, 1'b0, 1'b0);
    chk("ign_start_busy", bus.busy, 1'b1);
    repeat (3) tick();
    chk("pre_led", bus.stim_led, 1'b0);
    tick();
    chk("led_on", bus.stim_led, 1'b1);
    chk("entry_cnt", {bus.cnt_en, bus.cnt_reset}, 2'b11);
    cyc(1'b0, 1'b0, 1'b0);
    chk("react_cnt", {bus.cnt_en, bus.cnt_reset}, 2'b10);
    repeat (7) tick();
    chk("pre_valid", bus.result_valid, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    chk("norm_result", bus.result_ms, 10'd7);
    chk("norm_valid", bus.result_valid, 1'b1);
    chk("norm_flags", {bus.false_start, bus.timeout}, 2'b00);
    chk("norm_done_out", {bus.stim_led, bus.busy, bus.cnt_en, bus.cnt_reset}, 4'b0001);
    cyc(1'b0, 1'b0, 1'b0);
    chk("norm_valid_pulse", bus.result_valid, 1'b0);
    chk("norm_hold", bus.result_ms, 10'd7);
    bus.rand_val = 2'd0;
    cyc(1'b1, 1'b0, 1'b0);
    tick();
    chk("fs_led_low", bus.stim_led, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    chk("fs_flag", bus.false_start, 1'b1);
    chk("fs_result", bus.result_ms, 10'd0);
    chk("fs_valid", bus.result_valid, 1'b1);
    chk("fs_done", {bus.stim_led, bus.busy, bus.cnt_en}, 3'b000);
    cyc(1'b1, 1'b1, 1'b0);
    chk("fs_clear", bus.false_start, 1'b0);
    chk("start_beats_react", bus.busy, 1'b1);
    tick();
    tick();
    repeat (3) cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1);
    chk("fs_expiry_flag", bus.false_start, 1'b1);
    chk("fs_expiry_led", bus.stim_led, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    repeat (3) tick();
    repeat (19) tick();
    chk("to_pre", {bus.timeout, bus.stim_led}, 2'b01);
    tick();
    chk("to_flag", bus.timeout, 1'b1);
    chk("to_result", bus.result_ms, 10'd20);
    chk("to_valid", bus.result_valid, 1'b1);
    chk("to_led", bus.stim_led, 1'b0);
    bus.rand_val = 2'd1;
    cyc(1'b1, 1'b0, 1'b0);
    chk("to_clear", bus.timeout, 1'b0);
    repeat (4) tick();
    chk("sim_led", bus.stim_led, 1'b1);
    repeat (3) tick();
    repeat (3) cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1);
    chk("sim_result", bus.result_ms, 10'd3);
    chk("sim_flags", {bus.false_start, bus.timeout, bus.result_valid}, 3'b001);
    bus.rand_val = 2'd0;
    cyc(1'b1, 1'b0, 1'b0);
    repeat (5) tick();
    chk("mid_led", bus.stim_led, 1'b1);
    reset = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    chk("mid_rst_cnt", {bus.cnt_en, bus.cnt_reset}, 2'b01);
    chk("mid_rst_led", {bus.stim_led, bus.busy, bus.result_valid}, 3'b000);
    chk("mid_rst_result", bus.result_ms, 10'd0);
`ifdef REACTION_GAME_BEST_TIME_EN
    chk("best_rst", bus.best_ms, 10'h3ff);
    chk("new_best_rst", bus.new_best, 1'b0);
    reset = 1'b0;
    play(2'd1, 9);
    chk("best_g1", bus.best_ms, 10'd9);
    chk("nb_g1", {bus.new_best, bus.result_valid}, 2'b11);
    cyc(1'b0, 1'b0, 1'b0);
    chk("nb_pulse", bus.new_best, 1'b0);
    play(2'd2, 5);
    chk("best_g2", bus.best_ms, 10'd5);
    chk("nb_g2", bus.new_best, 1'b1);
    play(2'd0, 7);
    chk("res_g3", bus.result_ms, 10'd7);
    chk("best_g3", bus.best_ms, 10'd5);
    chk("nb_g3", bus.new_best, 1'b0);
`endif
    reset = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
